reloj_mtimer: RTL



---
 rtl/reloj_mtimer_pkg.sv | 37 +++
 rtl/reloj_mtimer_if.sv | 21 ++
 rtl/reloj_mtimer_channel.sv | 167 ++++++++++++++++
 rtl/reloj_mtimer.sv | 66 ++++++
 4 files changed

// File: rtl/reloj_mtimer_pkg.sv
// reloj_mtimer_pkg: shared register map, control/status bit positions and
// the bus address split used by the multi-channel interval timer.
package reloj_mtimer_pkg;

  // Per-channel register offsets (low three bits of the word address)
  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD_L = 3'd2;
  localparam logic [2:0] OFF_PERIOD_H = 3'd3;
  localparam logic [2:0] OFF_SNAP_L   = 3'd4;
  localparam logic [2:0] OFF_SNAP_H   = 3'd5;
  localparam logic [2:0] OFF_PRESCALE = 3'd6;

  // Status register bits
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  // Control register bits; START/STOP are write-only strobes
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // Widest address: 3 offset bits plus 2 channel bits for four channels
  localparam int ADDR_MAX_W = 5;

  typedef struct packed {
    logic [1:0] ch;
    logic [2:0] off;
  } addr_split_t;

  // Split a zero-extended word address into channel and register offset
  function automatic addr_split_t split_addr(input logic [ADDR_MAX_W-1:0] addr);
    return addr_split_t'(addr);
  endfunction

endpackage

// File: rtl/reloj_mtimer_if.sv
// reloj_mtimer_if: 16-bit Avalon-MM slave bus of the interval timer
// (word address, chipselect, active-low write, registered read data).
interface reloj_mtimer_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/reloj_mtimer_channel.sv
// reloj_mtimer_channel: one down-counter with period, control, status,
// snapshot and interrupt. Define RELOJ_MTIMER_PRESCALE_EN to add the
// 16-bit per-channel prescaler at offset 6; otherwise it ticks every clock.
module reloj_mtimer_channel
  import reloj_mtimer_pkg::*;
#(
  parameter int          COUNTER_W    = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h2FAF07F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  offset,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq
);

  localparam int                   HI_W      = COUNTER_W - 16;
  localparam logic [COUNTER_W-1:0] RESET_VAL = RESET_PERIOD[COUNTER_W-1:0];

  logic [COUNTER_W-1:0] counter_d, counter_q;
  logic [COUNTER_W-1:0] period_d, period_q;
  logic [COUNTER_W-1:0] snap_d, snap_q;
  logic run_d, run_q;
  logic to_d, to_q;
  logic ito_d, ito_q;
  logic cont_d, cont_q;
  logic nz_d, nz_q;

  logic wr_status, wr_control, wr_period, wr_snap;
  logic start, stop, tick, cnt_zero, to_event;

  assign wr_status  = wr_en && (offset == OFF_STATUS);
  assign wr_control = wr_en && (offset == OFF_CONTROL);
  assign wr_period  = wr_en && (offset == OFF_PERIOD_L || offset == OFF_PERIOD_H);
  assign wr_snap    = wr_en && (offset == OFF_SNAP_L || offset == OFF_SNAP_H);
  assign start      = wr_control && wdata[CTL_START];
  assign stop       = wr_control && wdata[CTL_STOP];
  assign cnt_zero   = (counter_q == '0);
  // Edge-detected: a counter parked at zero (period 0) fires only once
  assign to_event   = cnt_zero && nz_q;
  assign irq        = to_q && ito_q;

`ifdef RELOJ_MTIMER_PRESCALE_EN
  logic [15:0] presc_d, presc_q;
  logic [15:0] pcnt_d, pcnt_q;

  // >= so a prescale rewritten below the running count ticks promptly
  assign tick = (pcnt_q >= presc_q);

  // Prescale register and its running count, cleared on START and reload
  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (wr_en && offset == OFF_PRESCALE) presc_d = wdata;
    if (run_q) pcnt_d = tick ? '0 : pcnt_q + 16'd1;
    if (start || wr_period) pcnt_d = '0;
  end

  // Prescaler state
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next state for counter, period, run/timeout flags, control and snapshot
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    period_d  = period_q;
    counter_d = counter_q;
    snap_d    = snap_q;
    run_d     = run_q;
    to_d      = to_q;
    ito_d     = ito_q;
    cont_d    = cont_q;
    nz_d      = !cnt_zero;

    if (wr_en && offset == OFF_PERIOD_L) period_d[15:0] = wdata;
    if (wr_en && offset == OFF_PERIOD_H) period_d[COUNTER_W-1:16] = wdata[HI_W-1:0];

    // Count down on each tick; at zero reload instead of decrementing
    if (run_q && tick) begin
      if (cnt_zero) begin
        counter_d = period_q;
        if (!cont_q) run_d = 1'b0;
      end else begin
        counter_d = counter_q - COUNTER_W'(1);
      end
    end

    // A period write reloads the counter and halts it until re-started
    if (wr_period) begin
      counter_d = period_d;
      run_d     = 1'b0;
    end

    if (wr_control) begin
      ito_d  = wdata[CTL_ITO];
      cont_d = wdata[CTL_CONT];
      if (start)     run_d = 1'b1;
      else if (stop) run_d = 1'b0;
    end

    // Clear first so a coincident timeout event still sets TO
    if (wr_status) to_d = 1'b0;
    if (to_event)  to_d = 1'b1;

    if (wr_snap) snap_d = counter_q;
  end

  // Channel state registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      counter_q <= RESET_VAL;
      period_q  <= RESET_VAL;
      snap_q    <= '0;
      run_q     <= 1'b0;
      to_q      <= 1'b0;
      ito_q     <= 1'b0;
      cont_q    <= 1'b0;
      nz_q      <= 1'b0;
    end else begin
      counter_q <= counter_d;
      period_q  <= period_d;
      snap_q    <= snap_d;
      run_q     <= run_d;
      to_q      <= to_d;
      ito_q     <= ito_d;
      cont_q    <= cont_d;
      nz_q      <= nz_d;
    end
  end

  // Register read mux for this channel; unused and reserved bits read 0
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_STATUS: begin
        rdata[ST_TO]  = to_q;
        rdata[ST_RUN] = run_q;
      end
      OFF_CONTROL: begin
        rdata[CTL_ITO]  = ito_q;
        rdata[CTL_CONT] = cont_q;
      end
      OFF_PERIOD_L: rdata = period_q[15:0];
      OFF_PERIOD_H: rdata[HI_W-1:0] = period_q[COUNTER_W-1:16];
      OFF_SNAP_L:   rdata = snap_q[15:0];
      OFF_SNAP_H:   rdata[HI_W-1:0] = snap_q[COUNTER_W-1:16];
`ifdef RELOJ_MTIMER_PRESCALE_EN
      OFF_PRESCALE: rdata = presc_q;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/reloj_mtimer.sv
// reloj_mtimer: NUM_CH independent interval timers on a 16-bit Avalon-MM
// slave. Decodes the channel field, registers read data (one wait state)
// and ORs the per-channel interrupts. RELOJ_MTIMER_PRESCALE_EN enables the
// per-channel prescaler inside each channel.
module reloj_mtimer
  import reloj_mtimer_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          COUNTER_W    = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h2FAF07F
) (
  input  logic              clk,
  input  logic              reset,
  reloj_mtimer_if.slave     bus,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  addr_split_t       sel;
  logic              bus_wr;
  logic [NUM_CH-1:0] ch_wr;
  logic [15:0]       ch_rdata [NUM_CH];
  logic [15:0]       readdata_d, readdata_q;

  assign sel    = split_addr(ADDR_MAX_W'(bus.address));
  assign bus_wr = bus.chipselect && !bus.write_n;

  // Route a write to the addressed channel; out-of-range channels get none
  always_comb begin
    ch_wr = '0;
    for (int i = 0; i < NUM_CH; i++) ch_wr[i] = bus_wr && (int'(sel.ch) == i);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    reloj_mtimer_channel #(
      .COUNTER_W    (COUNTER_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (ch_wr[g]),
      .offset (sel.off),
      .wdata  (bus.writedata),
      .rdata  (ch_rdata[g]),
      .irq    (irq_vec[g])
    );
  end

  // Read mux over channels; addresses beyond NUM_CH return 0
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(sel.ch) == i) readdata_d = ch_rdata[i];
    end
  end

  // Read data register, refreshed every cycle from the address mux
  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign irq          = |irq_vec;

endmodule
